// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate unit applying one carry-chained single-bit step per clock
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [AMT_W-1:0] cnt;
  logic [2:0] op;
  logic accept, out_bit, fill;
  logic [WIDTH-1:0] stepped;
  // accept decision, next state and one single-bit step of the working value
  always_comb begin
    accept = start && state != SHIFT;
    state_nx = accept ? (amount == '0 ? DONE : SHIFT)
             : state == SHIFT ? (cnt == AMT_W'(1) ? DONE : SHIFT)
             : IDLE;
    out_bit = op[2] ? data_out[0] : data_out[WIDTH-1];
    fill = op[1:0] == 2'b00 ? 1'b0
         : op[1:0] == 2'b01 ? cout
         : op[1:0] == 2'b10 ? data_out[0]
         : data_out[WIDTH-1];
    stepped = op[2] ? {fill, data_out[WIDTH-1:1]} : {data_out[WIDTH-2:0], fill};
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // working value, carry and step counter; data_out/cout are the working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      cout <= 1'b0;
      cnt <= '0;
      op <= '0;
    end else if (accept) begin
      data_out <= data_in;
      cout <= cin;
      cnt <= amount;
      op <= mode;
    end else if (state == SHIFT) begin
      data_out <= stepped;
      cout <= out_bit;
      cnt <= cnt - 1'b1;
    end
  end
  assign ready = state != SHIFT;
  assign busy = state == SHIFT;
  assign done = state == DONE;
endmodule
